// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, requests words from instruction memory and hands IR/PC/opcode to decode.
// Optional macro IFU_MISALIGN_CHECK_EN traps misaligned redirects in FAULT instead of aligning them.
module instr_fetch_unit #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [31:0]     ir_instr,
    output logic [XLEN-1:0] ir_pc,
    output logic [6:0]      ir_opcode,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            discard;
    logic            discard_next;
    logic            ir_valid_next;
    logic [31:0]     ir_instr_next;
    logic [XLEN-1:0] ir_pc_next;
    logic            req_fire;
    logic            misaligned;
    logic [XLEN-1:0] target;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign ir_opcode = ir_instr[6:0];

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign target     = redirect_pc;
`else
    assign misaligned = 1'b0;
    assign target     = redirect_pc & WORD_MASK;
`endif

    // Redirect outranks every other event; a redirect that lands while a request is
    // in flight marks that response for dropping via the discard flag.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        discard_next  = discard;
        ir_valid_next = ir_valid;
        ir_instr_next = ir_instr;
        ir_pc_next    = ir_pc;

        if (misaligned) begin
            pc_next       = target;
            state_next    = S_FAULT;
            ir_valid_next = 1'b0;
            discard_next  = 1'b0;
            if (state == S_HOLD) begin
                ir_instr_next = NOP_INSTR;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_next = target;
                        if (req_fire) begin
                            discard_next = 1'b1;
                            state_next   = S_WAIT;
                        end
                    end else if (req_fire) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_next = target;
                        if (imem_rsp_valid) begin
                            discard_next = 1'b0;
                            state_next   = S_REQ;
                        end else begin
                            discard_next = 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (discard) begin
                            discard_next = 1'b0;
                            state_next   = S_REQ;
                        end else begin
                            ir_instr_next = imem_rsp_data;
                            ir_pc_next    = pc;
                            ir_valid_next = 1'b1;
                            state_next    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        ir_valid_next = 1'b0;
                        ir_instr_next = NOP_INSTR;
                        pc_next       = target;
                        state_next    = S_REQ;
                    end else if (ir_ready) begin
                        ir_valid_next = 1'b0;
                        pc_next       = pc + XLEN'(4);
                        state_next    = S_REQ;
                    end
                end
                S_FAULT: begin
                    if (redirect_valid) begin
                        pc_next    = target;
                        state_next = S_REQ;
                    end
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end
    end

    // Request outputs are registered from the next-state values so they change
    // one edge after the decision, including the first rise after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            discard        <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            ir_valid       <= 1'b0;
            ir_instr       <= NOP_INSTR;
            ir_pc          <= RESET_PC;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            discard        <= discard_next;
            imem_req_valid <= (state_next == S_REQ);
            imem_req_addr  <= pc_next;
            ir_valid       <= ir_valid_next;
            ir_instr       <= ir_instr_next;
            ir_pc          <= ir_pc_next;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_next == S_FAULT);
        end
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios followed by a randomized run checked against a transaction-level scoreboard.
// Misaligned-redirect expectations follow IFU_MISALIGN_CHECK_EN.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_instr;
    logic [31:0] ir_pc;
    logic [6:0]  ir_opcode;
    logic        fetch_fault;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_instr       (ir_instr),
        .ir_pc          (ir_pc),
        .ir_opcode      (ir_opcode),
        .fetch_fault    (fetch_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rr, input logic rv, input logic [31:0] rdata,
                                  input logic rdv, input logic [31:0] rpc, input logic irr);
        imem_req_ready = rr;
        imem_rsp_valid = rv;
        imem_rsp_data  = rdata;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        ir_ready       = irr;
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    initial begin
        logic        outstanding;
        logic        stale;
        logic [31:0] out_addr;
        logic [31:0] exp_addr;
        logic        exp_ir_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_req_valid;
        logic        rr, rsp, rd, irr, hs, cons;
        logic [31:0] raw, tgt;

        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_output("rst_req_valid", imem_req_valid, 0);
        check_output("rst_req_addr", imem_req_addr, 0);
        check_output("rst_ir_valid", ir_valid, 0);
        check_output("rst_ir_instr", ir_instr, NOP);
        check_output("rst_ir_pc", ir_pc, 0);
        check_output("rst_opcode", ir_opcode, 7'h13);
        check_output("rst_fault", fetch_fault, 0);

        rst_n = 1'b1;
        tick();
        check_output("first_req_valid", imem_req_valid, 1);
        check_output("first_req_addr", imem_req_addr, 0);
        repeat (3) begin
            tick();
            check_output("stall_req_valid", imem_req_valid, 1);
            check_output("stall_req_addr", imem_req_addr, 0);
        end
        apply_stimulus(1, 0, 0, 0, 0, 0);
        tick();
        check_output("issued_req_valid", imem_req_valid, 0);
        apply_stimulus(0, 1, 32'h0050_0093, 0, 0, 0);
        tick();
        check_output("cap_ir_valid", ir_valid, 1);
        check_output("cap_ir_instr", ir_instr, 32'h0050_0093);
        check_output("cap_ir_pc", ir_pc, 0);
        check_output("cap_opcode", ir_opcode, 7'b0010011);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        repeat (5) begin
            tick();
            check_output("hold_ir_valid", ir_valid, 1);
            check_output("hold_ir_instr", ir_instr, 32'h0050_0093);
            check_output("hold_ir_pc", ir_pc, 0);
            check_output("hold_req_valid", imem_req_valid, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 1);
        tick();
        check_output("consume_ir_valid", ir_valid, 0);
        check_output("consume_req_valid", imem_req_valid, 1);
        check_output("consume_req_addr", imem_req_addr, 32'h4);

        // Redirect while waiting: the in-flight response must be dropped.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 1, 32'h100, 0);
        tick();
        check_output("wait_redir_req_valid", imem_req_valid, 0);
        apply_stimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        tick();
        check_output("drop_ir_valid", ir_valid, 0);
        check_output("drop_ir_instr", ir_instr, 32'h0050_0093);
        check_output("drop_req_valid", imem_req_valid, 1);
        check_output("drop_req_addr", imem_req_addr, 32'h100);

        // Redirect and consume in the same HOLD cycle.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 1, 32'h00A0_0113, 0, 0, 0);
        tick();
        check_output("cap2_ir_pc", ir_pc, 32'h100);
        apply_stimulus(0, 0, 0, 1, 32'h200, 1);
        tick();
        check_output("flush_ir_valid", ir_valid, 0);
        check_output("flush_ir_instr", ir_instr, NOP);
        check_output("flush_req_addr", imem_req_addr, 32'h200);

        // Redirect in REQ without handshake, then wrap past the top of memory.
        apply_stimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        tick();
        check_output("req_redir_valid", imem_req_valid, 1);
        check_output("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 1, 32'h1234_5678, 0, 0, 0);
        tick();
        check_output("top_ir_pc", ir_pc, 32'hFFFF_FFFC);
        check_output("top_opcode", ir_opcode, 7'h78);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        tick();
        check_output("wrap_req_addr", imem_req_addr, 32'h0);

        // Redirect coinciding with a handshake: old request's response is discarded.
        apply_stimulus(1, 0, 0, 1, 32'h300, 0);
        tick();
        check_output("hs_redir_req_valid", imem_req_valid, 0);
        apply_stimulus(0, 1, 32'hCAFE_0033, 0, 0, 0);
        tick();
        check_output("hs_drop_ir_valid", ir_valid, 0);
        check_output("hs_drop_ir_instr", ir_instr, 32'h1234_5678);
        check_output("hs_drop_req_addr", imem_req_addr, 32'h300);

        // Redirect with response in the same WAIT cycle.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 1, 32'h0BAD_F00D, 1, 32'h400, 0);
        tick();
        check_output("same_drop_ir_valid", ir_valid, 0);
        check_output("same_drop_ir_instr", ir_instr, 32'h1234_5678);
        check_output("same_drop_req_valid", imem_req_valid, 1);
        check_output("same_drop_req_addr", imem_req_addr, 32'h400);

        apply_stimulus(0, 0, 0, 1, 32'h102, 0);
        tick();
`ifdef IFU_MISALIGN_CHECK_EN
        check_output("mis_fault", fetch_fault, 1);
        check_output("mis_req_valid", imem_req_valid, 0);
        check_output("mis_ir_valid", ir_valid, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        check_output("mis_fault_held", fetch_fault, 1);
        apply_stimulus(0, 0, 0, 1, 32'h106, 0);
        tick();
        check_output("mis_fault_again", fetch_fault, 1);
        check_output("mis_again_req_valid", imem_req_valid, 0);
`else
        check_output("mis_fault", fetch_fault, 0);
        check_output("mis_req_valid", imem_req_valid, 1);
        check_output("mis_req_addr", imem_req_addr, 32'h100);
`endif
        apply_stimulus(0, 0, 0, 1, 32'h104, 0);
        tick();
        check_output("align_fault", fetch_fault, 0);
        check_output("align_req_valid", imem_req_valid, 1);
        check_output("align_req_addr", imem_req_addr, 32'h104);

        // Randomized run against a scoreboard of requests, responses and deliveries.
        outstanding  = 1'b0;
        stale        = 1'b0;
        out_addr     = 32'h0;
        exp_addr     = 32'h104;
        exp_ir_valid = 1'b0;
        exp_instr    = 32'h1234_5678;
        exp_pc       = 32'h0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_req_valid = !outstanding && !exp_ir_valid;
            check_output("rnd_req_valid", imem_req_valid, exp_req_valid);
            if (exp_req_valid) check_output("rnd_req_addr", imem_req_addr, exp_addr);
            check_output("rnd_ir_valid", ir_valid, exp_ir_valid);
            check_output("rnd_ir_instr", ir_instr, exp_instr);
            if (exp_ir_valid) check_output("rnd_ir_pc", ir_pc, exp_pc);
            check_output("rnd_opcode", ir_opcode, exp_instr[6:0]);
            check_output("rnd_fault", fetch_fault, 0);

            rr  = ($urandom_range(0, 3) != 0);
            rsp = outstanding && ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            irr = ($urandom_range(0, 1) == 1);
            raw = $urandom;
            if ($urandom_range(0, 7) == 0) raw = 32'hFFFF_FFFC;
`ifdef IFU_MISALIGN_CHECK_EN
            raw[1:0] = 2'b00;
`endif
            tgt = raw & 32'hFFFF_FFFC;
            apply_stimulus(rr, rsp, rsp ? mem_word(out_addr) : $urandom, rd, raw, irr);

            hs   = exp_req_valid && rr;
            cons = exp_ir_valid && irr;
            if (rd) begin
                if (hs) begin
                    outstanding = 1'b1;
                    out_addr    = exp_addr;
                    stale       = 1'b1;
                end else if (rsp) begin
                    outstanding = 1'b0;
                    stale       = 1'b0;
                end else if (outstanding) begin
                    stale = 1'b1;
                end
                if (exp_ir_valid) begin
                    exp_ir_valid = 1'b0;
                    exp_instr    = NOP;
                end
                exp_addr = tgt;
            end else begin
                if (hs) begin
                    outstanding = 1'b1;
                    out_addr    = exp_addr;
                    stale       = 1'b0;
                end
                if (rsp) begin
                    outstanding = 1'b0;
                    if (!stale) begin
                        exp_ir_valid = 1'b1;
                        exp_instr    = mem_word(out_addr);
                        exp_pc       = out_addr;
                    end
                    stale = 1'b0;
                end
                if (cons) begin
                    exp_ir_valid = 1'b0;
                    exp_addr     = exp_pc + 32'd4;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
